// File: rtl/pss_tx_source.sv
`default_nettype none
// ============================================================================
//  Module      : pss_tx_source
//  Description : Transmit-side NR PSS waveform source. Emits the 127-symbol
//                BPSK m-sequence for a chosen N_id_2 as AXI-stream IQ samples,
//                sample-and-hold by INTERP, separated by a programmable zero
//                gap, with a per-sample DDS phase word accumulating a CFO.
//  Revision    : 1.0  initial release
// ============================================================================
module pss_tx_source #(
  parameter int OUT_DW       = 32,
  parameter int AMPLITUDE    = 2**(OUT_DW/2-1)-1,
  parameter int INTERP       = 2,
  parameter int GAP_DW       = 16,
  parameter int DDS_PHASE_DW = 20
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    start_i,
  input  logic [1:0]              N_id_2_i,
  input  logic                    continuous_i,
  input  logic [GAP_DW-1:0]       gap_len_i,
  input  logic [DDS_PHASE_DW-1:0] CFO_norm_i,
  input  logic                    CFO_norm_valid_i,
  output logic [OUT_DW-1:0]       m_axis_out_tdata,
  output logic                    m_axis_out_tvalid,
  input  logic                    m_axis_out_tready,
  output logic                    m_axis_out_tlast,
  output logic [DDS_PHASE_DW-1:0] m_axis_phase_tdata,
  output logic                    busy_o,
  output logic                    error_o
);

  localparam int c_hw     = OUT_DW / 2;
  localparam int c_hold_w = (INTERP > 1) ? $clog2(INTERP) : 1;
  localparam logic [c_hold_w-1:0] c_hold_max = c_hold_w'(INTERP - 1);
  localparam logic [c_hold_w-1:0] c_hold_one = c_hold_w'(1);
  localparam logic [GAP_DW-1:0]   c_gap_one  = GAP_DW'(1);
  localparam logic [c_hw-1:0]     c_amp_pos  = c_hw'(AMPLITUDE);
  localparam logic [c_hw-1:0]     c_amp_neg  = c_hw'(-AMPLITUDE);

  // Whole m-sequence x(0..126) unrolled at elaboration, so any cyclic offset
  // is a plain table lookup and restarts never stall.
  function automatic logic [126:0] f_gen_x();
    logic [126:0] x;
    x      = '0;
    x[6:0] = 7'b1110110;
    for (int i = 0; i < 120; i++) begin
      x[i+7] = x[i+4] ^ x[i];
    end
    return x;
  endfunction

  localparam logic [126:0] c_xseq = f_gen_x();

  // Starting index m for n=0: 43*N_id_2 mod 127.
  function automatic logic [6:0] f_offset(input logic [1:0] nid);
    case (nid)
      2'd1:    return 7'd43;
      2'd2:    return 7'd86;
      default: return 7'd0;
    endcase
  endfunction

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEQ  = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t                  r_state, w_state_nxt;
  logic [1:0]              r_nid, w_nid_nxt;
  logic [GAP_DW-1:0]       r_gap_len, w_gap_len_nxt;
  logic [GAP_DW-1:0]       r_gap_left, w_gap_left_nxt;
  logic [6:0]              r_n, w_n_nxt;
  logic [6:0]              r_m, w_m_nxt;
  logic [c_hold_w-1:0]     r_hold, w_hold_nxt;
  logic [DDS_PHASE_DW-1:0] r_phase, w_phase_nxt;
  logic [DDS_PHASE_DW-1:0] r_cfo;
  logic                    r_error, w_error_nxt;
  logic                    w_xfer;
  logic                    w_decide;
  logic [c_hw-1:0]         w_real;

  assign w_xfer = (r_state != S_IDLE) && m_axis_out_tready;
  assign w_real = c_xseq[r_m] ? c_amp_neg : c_amp_pos;

  // Next-state logic: counters only advance on an accepted transfer.
  always_comb begin
    w_state_nxt    = r_state;
    w_nid_nxt      = r_nid;
    w_gap_len_nxt  = r_gap_len;
    w_gap_left_nxt = r_gap_left;
    w_n_nxt        = r_n;
    w_m_nxt        = r_m;
    w_hold_nxt     = r_hold;
    w_phase_nxt    = w_xfer ? (r_phase + r_cfo) : r_phase;
    w_error_nxt    = 1'b0;
    w_decide       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          if (N_id_2_i != 2'd3) begin
            w_state_nxt   = S_SEQ;
            w_nid_nxt     = N_id_2_i;
            w_gap_len_nxt = gap_len_i;
            w_n_nxt       = 7'd0;
            w_m_nxt       = f_offset(N_id_2_i);
            w_hold_nxt    = '0;
            w_phase_nxt   = '0;
          end else begin
            w_error_nxt = 1'b1;
          end
        end
      end
      S_SEQ: begin
        if (w_xfer) begin
          if (r_hold == c_hold_max) begin
            w_hold_nxt = '0;
            if (r_n == 7'd126) begin
              if (r_gap_len != '0) begin
                w_state_nxt    = S_GAP;
                w_gap_left_nxt = r_gap_len - c_gap_one;
              end else begin
                w_decide = 1'b1;
              end
            end else begin
              w_n_nxt = r_n + 7'd1;
              w_m_nxt = (r_m == 7'd126) ? 7'd0 : (r_m + 7'd1);
            end
          end else begin
            w_hold_nxt = r_hold + c_hold_one;
          end
        end
      end
      S_GAP: begin
        if (w_xfer) begin
          if (r_gap_left == '0) begin
            w_decide = 1'b1;
          end else begin
            w_gap_left_nxt = r_gap_left - c_gap_one;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // End of a sequence+gap: repeat back-to-back or fall back to idle.
    if (w_decide) begin
      if (continuous_i) begin
        w_state_nxt = S_SEQ;
        w_n_nxt     = 7'd0;
        w_m_nxt     = f_offset(r_nid);
        w_hold_nxt  = '0;
      end else begin
        w_state_nxt = S_IDLE;
      end
    end
  end

  // State and datapath registers; CFO load uses the old value for this edge's increment.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state    <= S_IDLE;
      r_nid      <= '0;
      r_gap_len  <= '0;
      r_gap_left <= '0;
      r_n        <= '0;
      r_m        <= '0;
      r_hold     <= '0;
      r_phase    <= '0;
      r_cfo      <= '0;
      r_error    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_nid      <= w_nid_nxt;
      r_gap_len  <= w_gap_len_nxt;
      r_gap_left <= w_gap_left_nxt;
      r_n        <= w_n_nxt;
      r_m        <= w_m_nxt;
      r_hold     <= w_hold_nxt;
      r_phase    <= w_phase_nxt;
      r_error    <= w_error_nxt;
      if (CFO_norm_valid_i) begin
        r_cfo <= CFO_norm_i;
      end
    end
  end

  assign m_axis_out_tvalid  = (r_state != S_IDLE);
  assign m_axis_out_tdata   = (r_state == S_SEQ) ? {{(OUT_DW-c_hw){1'b0}}, w_real} : '0;
  assign m_axis_out_tlast   = (r_state == S_SEQ) && (r_n == 7'd126) && (r_hold == c_hold_max);
  assign m_axis_phase_tdata = r_phase;
  assign busy_o             = (r_state != S_IDLE);
  assign error_o            = r_error;

endmodule
`default_nettype wire

// File: doc/pss_tx_source.md
Name: pss_tx_source

Overview:
- Transmit-side PSS waveform source for the 5G PHY test chain.
- Generates the 127-symbol NR PSS BPSK m-sequence for a selected N_id_2 and holds each symbol for INTERP samples.
- Separates sequences with a programmable zero gap and emits AXI-stream IQ samples.
- Emits a per-sample DDS phase word accumulating a programmable CFO, so a downstream dds plus complex_multiplier impairs the signal before it reaches the receive correlator.

Parameters:
- OUT_DW, 32, IQ sample width; real part in [OUT_DW/2-1:0], imag part in [OUT_DW-1:OUT_DW/2].
- AMPLITUDE, 2**(OUT_DW/2-1)-1, signed magnitude emitted for a +1 symbol.
- INTERP, 2, samples per PSS symbol (sample-and-hold), >=1.
- GAP_DW, 16, width of the gap length input.
- DDS_PHASE_DW, 20, phase accumulator width.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous reset, active-high
- start_i  in  1  start request, accepted only in IDLE
- N_id_2_i  in  2  PSS index 0..2; sampled on start acceptance
- continuous_i  in  1  repeat sequence after gap; sampled at end of each gap
- gap_len_i  in  GAP_DW  zero samples after each sequence; sampled on start acceptance
- CFO_norm_i  in  DDS_PHASE_DW  phase increment per sample (two's complement)
- CFO_norm_valid_i  in  1  load strobe for CFO_norm_i
- m_axis_out_tdata  out  OUT_DW  IQ sample
- m_axis_out_tvalid  out  1  sample valid
- m_axis_out_tready  in  1  downstream ready
- m_axis_out_tlast  out  1  last sample of a 127*INTERP sequence
- m_axis_phase_tdata  out  DDS_PHASE_DW  phase word aligned with m_axis_out_tdata
- busy_o  out  1  high when not in IDLE
- error_o  out  1  one-cycle pulse when start is rejected because N_id_2_i==3

Behaviour:
- Reset: IDLE, all outputs 0, CFO register 0, phase 0, LFSR reloaded.
- Transfer: a transfer occurs when tvalid && tready. While tvalid is high and tready is low, tdata, tlast and phase_tdata hold stable.
- States: IDLE, SEQ, GAP.
- IDLE -> SEQ:
  - Condition: start_i && N_id_2_i!=3.
  - Latch N_id_2 and gap_len; phase reset to 0.
  - tvalid rises on the next cycle, presenting symbol n=0.
- Rejected start: start_i with N_id_2_i==3 stays in IDLE and pulses error_o. start_i in SEQ or GAP is ignored, with no error.
- Sequence definition:
  - x(i+7) = x(i+4) xor x(i), with init x(6..0) = 1,1,1,0,1,1,0.
  - d(n) = 1-2*x(m), m = (n + 43*N_id_2) mod 127, n = 0..126.
  - Implementation choice is free (LFSR advanced from offset, or ROM), but the required m must be available with no stall cycles.
- Sample value: real = +AMPLITUDE or -AMPLITUDE (two's complement, OUT_DW/2 bits); imag = 0.
- Symbol hold: each d(n) is held for INTERP consecutive transfers, then n increments.
- tlast: asserted on transfer number 127*INTERP of the sequence only.
- SEQ exit: after the tlast transfer, go to GAP if gap_len>0, else apply the end-of-gap decision immediately.
- GAP: emits gap_len samples with tdata=0, tvalid=1, tlast=0.
- End-of-gap decision: if continuous_i is high, restart SEQ at n=0 with no idle cycle; otherwise go to IDLE with tvalid=0 on the following cycle.
- Phase: cleared on start acceptance; not cleared on continuous restart, so phase is continuous across repeats.
- Phase increment: phase += CFO register on every transfer (SEQ and GAP), modulo 2**DDS_PHASE_DW. The first sample carries phase 0.
- CFO register:
  - Loads CFO_norm_i when CFO_norm_valid_i is high, in any state.
  - A load in the same cycle as a transfer affects only subsequent increments.
  - The increment always uses the registered value, never CFO_norm_i directly.
- Reset mid-operation: immediate return to IDLE. tvalid is 0 on the cycle after reset is sampled; no partial tlast.
- Throughput: one sample per cycle under continuous tready; no bubbles between SEQ, GAP and repeat.

Test Plan:
- N_id_2=0, INTERP=1, gap=0, tready=1, continuous=0, start pulse -> tvalid one cycle later; real = +A,-A,-A,+A,-A,... (A=32767); 127 samples; tlast on sample 127; busy_o falls after it.
- N_id_2=0, INTERP=2, gap=3 -> real = +A,+A,-A,-A,...; tlast on sample 254; then 3 zero samples; then IDLE.
- Random tready (50%) with N_id_2=1 -> transferred stream equals the golden model for m=(n+43) mod 127; data and phase stable during stalls; tlast count = 1.
- CFO_norm=0x00100, continuous=1, gap=1, INTERP=1 -> phase_tdata = 0, 0x100, 0x200, ... on successive transfers; wraps modulo 2^20 on every 4096th transfer; second sequence starts at phase 0x8000 (128×0x100) with no idle cycle. CFO_norm_valid with 0x00200 mid-sequence -> step changes starting with the next transfer.
- start with N_id_2=3 -> error_o pulses one cycle, busy_o stays 0. start during SEQ -> ignored, no error.
- reset_i asserted at sample 50 -> tvalid=0 next cycle, phase=0. A fresh start then restarts at d(0) with correct values.
